// File: rtl/serv_bus_arbiter_pkg.sv
// Shared types for the SERV instruction/data bus arbiter: grant FSM states,
// grant identifiers, the per-master Wishbone request bundle and a width helper.
package serv_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } grant_e;

  // The instruction bus only ever performs full-word reads.
  localparam logic [3:0] IBUS_SEL = 4'hf;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } wb_req_t;

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serv_bus_watchdog.sv
// Transaction watchdog: counts granted cycles without an ack and flags the
// cycle in which the limit is reached. Collapses to a constant 0 when TIMEOUT = 0.
module serv_bus_watchdog
  import serv_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_ack,
  output logic o_expire
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int             CNT_W = cnt_width(TIMEOUT);
      localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // NOTE: cnt_d gets its default before any branch so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
          cnt_d = '0;
        end else if (i_en && !i_ack && (cnt_q != LAST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // NOTE: state registers use non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of block ordering.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // An ack in the final cycle completes the transfer instead of aborting it.
      assign o_expire = i_en && !i_ack && (cnt_q == LAST);
    end else begin : g_no_wd
      logic unused_wd;
      assign unused_wd = &{1'b0, i_clk, i_rst_n, i_clr, i_en, i_ack};
      assign o_expire  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone slave port between the SERV instruction and data buses
// using a registered round-robin grant FSM with a mandatory turnaround cycle.
module serv_bus_arbiter
  import serv_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  state_e  state_q, state_d;
  grant_e  last_grant_q, last_grant_d;

  logic    in_gnt;
  logic    granted_cyc;
  logic    wd_expire;

  wb_req_t ibus_req;
  wb_req_t dbus_req;
  wb_req_t wb_req;

  assign ibus_req = '{adr: i_ibus_adr, dat: 32'h0, sel: IBUS_SEL, we: 1'b0, cyc: i_ibus_cyc};
  assign dbus_req = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we,
                      cyc: i_dbus_cyc};

  assign in_gnt      = (state_q == GNT_I) || (state_q == GNT_D);
  assign granted_cyc = ((state_q == GNT_I) && i_ibus_cyc) || ((state_q == GNT_D) && i_dbus_cyc);

  serv_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (!in_gnt),
    .i_en     (in_gnt),
    .i_ack    (i_wb_ack),
    .o_expire (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time gets the bus.
        if (i_dbus_cyc && (!i_ibus_cyc || (last_grant_q == GNT_IBUS))) begin
          state_d      = GNT_D;
          last_grant_d = GNT_DBUS;
        end else if (i_ibus_cyc) begin
          state_d      = GNT_I;
          last_grant_d = GNT_IBUS;
        end
      end
      GNT_I, GNT_D: begin
        if (i_wb_ack || !granted_cyc || wd_expire) begin
          state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IBUS;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output mux is purely combinational on state_q so reset drops the bus at once.
  always_comb begin
    wb_req     = '0;
    o_ibus_ack = 1'b0;
    o_ibus_err = 1'b0;
    o_dbus_ack = 1'b0;
    o_dbus_err = 1'b0;
    case (state_q)
      GNT_I: begin
        wb_req     = ibus_req;
        o_ibus_ack = i_wb_ack;
        o_ibus_err = wd_expire && i_ibus_cyc;
      end
      GNT_D: begin
        wb_req     = dbus_req;
        o_dbus_ack = i_wb_ack;
        o_dbus_err = wd_expire && i_dbus_cyc;
      end
      default: wb_req = '0;
    endcase
  end

  assign o_wb_adr   = wb_req.adr;
  assign o_wb_dat   = wb_req.dat;
  assign o_wb_sel   = wb_req.sel;
  assign o_wb_we    = wb_req.we;
  assign o_wb_cyc   = wb_req.cyc;
  assign o_wb_stb   = wb_req.cyc;

  assign o_ibus_rdt = i_wb_rdt;
  assign o_dbus_rdt = i_wb_rdt;

  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Self-checking bench for serv_bus_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_serv_bus_arbiter;

  localparam int TIMEOUT = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        o_ibus_err;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        o_dbus_err;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  serv_bus_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .o_ibus_err (o_ibus_err),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .o_dbus_err (o_dbus_err),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_busy     (o_busy)
  );

  // Control snapshot: {busy, cyc, stb, we, sel[3:0], iack, ierr, dack, derr}
  function automatic logic [11:0] ctrl();
    return {o_busy, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel,
            o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic quiesce();
    i_ibus_cyc = 1'b0; i_ibus_adr = '0;
    i_dbus_cyc = 1'b0; i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0;
    i_wb_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    quiesce();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    quiesce();
    i_rst_n = 1'b0; i_wb_rdt = 32'hA5A5_5A5A; i_wb_ack = 1'b1; i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    @(negedge i_clk); @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL reset_ctrl got %h exp %h", ctrl(), 12'h000);
    end
    n_tests++;
    if ({o_wb_adr, o_wb_dat} !== 64'h0) begin
      n_fail++; $display("FAIL reset_adr_dat got %h exp 0", {o_wb_adr, o_wb_dat});
    end
    n_tests++;
    if ({o_ibus_rdt, o_dbus_rdt} !== {2{32'hA5A5_5A5A}}) begin
      n_fail++; $display("FAIL reset_rdt_passthru got %h exp %h", {o_ibus_rdt, o_dbus_rdt},
                         {2{32'hA5A5_5A5A}});
    end
    i_rst_n = 1'b1;
    quiesce();
    i_wb_ack = 1'b1;
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL spurious_ack_idle got %h exp %h", ctrl(), 12'h000);
    end
    i_wb_ack = 1'b0;
  endtask

  task automatic test_ibus_fetch();
    @(negedge i_clk); i_ibus_cyc = 1'b1; i_ibus_adr = 32'h100; #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL fetch_req_idle got %h exp %h", ctrl(), 12'h000);
    end
    @(negedge i_clk); #1;
    n_tests++;
    if ({ctrl(), o_wb_adr, o_wb_dat} !== {12'hEF0, 32'h100, 32'h0}) begin
      n_fail++; $display("FAIL fetch_grant got %h exp %h", {ctrl(), o_wb_adr, o_wb_dat},
                         {12'hEF0, 32'h100, 32'h0});
    end
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'hEF0) begin
      n_fail++; $display("FAIL fetch_wait got %h exp %h", ctrl(), 12'hEF0);
    end
    @(negedge i_clk); i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFE_0100; #1;
    n_tests++;
    if ({ctrl(), o_ibus_rdt} !== {12'hEF8, 32'hCAFE_0100}) begin
      n_fail++; $display("FAIL fetch_ack got %h exp %h", {ctrl(), o_ibus_rdt}, {12'hEF8, 32'hCAFE_0100});
    end
    @(negedge i_clk); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL fetch_turn got %h exp %h", ctrl(), 12'h800);
    end
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL fetch_idle got %h exp %h", ctrl(), 12'h000);
    end
  endtask

  task automatic test_tie_break();
    do_reset();
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h2000; i_dbus_dat = 32'hDEAD_BEEF; i_dbus_sel = 4'h3;
    i_dbus_we = 1'b1; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h300;
    @(negedge i_clk); i_wb_ack = 1'b1; #1;
    n_tests++;
    if ({ctrl(), o_wb_adr, o_wb_dat} !== {12'hF32, 32'h2000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL tie1_dbus_wins got %h exp %h", {ctrl(), o_wb_adr, o_wb_dat},
                         {12'hF32, 32'h2000, 32'hDEAD_BEEF});
    end
    @(negedge i_clk); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL tie1_turn got %h exp %h", ctrl(), 12'h800);
    end
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h2004; i_dbus_sel = 4'hf; i_dbus_dat = 32'h0; #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL tie2_idle got %h exp %h", ctrl(), 12'h000);
    end
    @(negedge i_clk); i_wb_ack = 1'b1; #1;
    n_tests++;
    if ({ctrl(), o_wb_adr} !== {12'hEF8, 32'h300}) begin
      n_fail++; $display("FAIL tie2_ibus_wins got %h exp %h", {ctrl(), o_wb_adr}, {12'hEF8, 32'h300});
    end
    @(negedge i_clk); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL tie2_turn got %h exp %h", ctrl(), 12'h800);
    end
    @(negedge i_clk);
    @(negedge i_clk); i_wb_ack = 1'b1; #1;
    n_tests++;
    if ({ctrl(), o_wb_adr} !== {12'hEF2, 32'h2004}) begin
      n_fail++; $display("FAIL tie2_dbus_after got %h exp %h", {ctrl(), o_wb_adr}, {12'hEF2, 32'h2004});
    end
    @(negedge i_clk); quiesce();
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL tie_end_idle got %h exp %h", ctrl(), 12'h000);
    end
  endtask

  task automatic test_back_to_back();
    int  low_run  = 0;
    int  n_acks   = 0;
    bit  seen     = 1'b0;
    bit  ack_prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (ack_prev) begin
        i_dbus_cyc = 1'b0;
      end else if (!i_dbus_cyc) begin
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h40 + 32'(4 * c); i_dbus_sel = 4'hf; i_dbus_we = 1'b0;
      end
      #1 i_wb_ack = o_wb_cyc;
      #1;
      if (o_wb_cyc) begin
        n_acks++;
        n_tests++;
        if (ctrl() !== 12'hEF2) begin
          n_fail++; $display("FAIL b2b_ack_dbus_only got %h exp %h", ctrl(), 12'hEF2);
        end
        if (seen) begin
          n_tests++;
          if (low_run != 2) begin
            n_fail++; $display("FAIL b2b_gap cyc low for %0d cycles exp 2", low_run);
          end
        end
        seen    = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
        n_tests++;
        if (ctrl() & 12'h00F) begin
          n_fail++; $display("FAIL b2b_no_resp_when_idle got %h exp %h", ctrl() & 12'h00F, 12'h000);
        end
      end
      ack_prev = o_dbus_ack;
    end
    n_tests++;
    if (n_acks != 4) begin
      n_fail++; $display("FAIL b2b_txn_count got %0d exp 4", n_acks);
    end
    quiesce();
    @(negedge i_clk);
  endtask

  task automatic test_watchdog_expire();
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h80; i_dbus_sel = 4'hf; i_dbus_we = 1'b0;
    for (int g = 1; g <= TIMEOUT; g++) begin
      @(negedge i_clk);
      if (g == 3) begin
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h500;
      end
      #1;
      n_tests++;
      if (ctrl() !== ((g == TIMEOUT) ? 12'hEF1 : 12'hEF0)) begin
        n_fail++; $display("FAIL wd_cycle%0d got %h exp %h", g, ctrl(),
                           (g == TIMEOUT) ? 12'hEF1 : 12'hEF0);
      end
    end
    @(negedge i_clk); i_dbus_cyc = 1'b0; #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL wd_turn got %h exp %h", ctrl(), 12'h800);
    end
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL wd_idle got %h exp %h", ctrl(), 12'h000);
    end
    @(negedge i_clk); i_wb_ack = 1'b1; #1;
    n_tests++;
    if ({ctrl(), o_wb_adr} !== {12'hEF8, 32'h500}) begin
      n_fail++; $display("FAIL wd_ibus_grant got %h exp %h", {ctrl(), o_wb_adr}, {12'hEF8, 32'h500});
    end
    @(negedge i_clk); quiesce();
    @(negedge i_clk);
  endtask

  task automatic test_ack_on_last();
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h84; i_dbus_sel = 4'hf; i_dbus_we = 1'b0;
    for (int g = 1; g <= TIMEOUT; g++) begin
      @(negedge i_clk);
      i_wb_ack = (g == TIMEOUT);
      #1;
      n_tests++;
      if (ctrl() !== ((g == TIMEOUT) ? 12'hEF2 : 12'hEF0)) begin
        n_fail++; $display("FAIL ack_last_cycle%0d got %h exp %h", g, ctrl(),
                           (g == TIMEOUT) ? 12'hEF2 : 12'hEF0);
      end
    end
    @(negedge i_clk); i_dbus_cyc = 1'b0; i_wb_ack = 1'b1; #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL spurious_ack_turn got %h exp %h", ctrl(), 12'h800);
    end
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL spurious_ack_idle2 got %h exp %h", ctrl(), 12'h000);
    end
    quiesce();
  endtask

  task automatic test_abort();
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h88; i_dbus_sel = 4'hf; i_dbus_we = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'hEF0) begin
      n_fail++; $display("FAIL abort_granted got %h exp %h", ctrl(), 12'hEF0);
    end
    @(negedge i_clk); i_dbus_cyc = 1'b0; #1;
    n_tests++;
    if (ctrl() !== 12'h8F0) begin
      n_fail++; $display("FAIL abort_drop got %h exp %h", ctrl(), 12'h8F0);
    end
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'h800) begin
      n_fail++; $display("FAIL abort_turn got %h exp %h", ctrl(), 12'h800);
    end
    quiesce();
    @(negedge i_clk);
  endtask

  task automatic test_async_reset();
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h3000; i_dbus_dat = 32'h1234; i_dbus_sel = 4'hc; i_dbus_we = 1'b1;
    @(negedge i_clk); #1;
    n_tests++;
    if (ctrl() !== 12'hFC0) begin
      n_fail++; $display("FAIL arst_pre_granted got %h exp %h", ctrl(), 12'hFC0);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ctrl(), o_wb_adr} !== {12'h000, 32'h0}) begin
      n_fail++; $display("FAIL arst_immediate_drop got %h exp %h", {ctrl(), o_wb_adr}, {12'h000, 32'h0});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h600; #1;
    n_tests++;
    if (ctrl() !== 12'h000) begin
      n_fail++; $display("FAIL arst_post_idle got %h exp %h", ctrl(), 12'h000);
    end
    @(negedge i_clk); i_wb_ack = 1'b1; #1;
    n_tests++;
    if ({ctrl(), o_wb_adr} !== {12'hFC2, 32'h3000}) begin
      n_fail++; $display("FAIL arst_tie_dbus got %h exp %h", {ctrl(), o_wb_adr}, {12'hFC2, 32'h3000});
    end
    @(negedge i_clk); quiesce();
    @(negedge i_clk);
  endtask

  // Reference model: owner of the bus (0 none, 1 ibus, 2 dbus), a pending
  // turnaround, the last winner and the number of cycles spent waiting for ack.
  task automatic test_random();
    int             m_owner = 0;
    bit             m_turn  = 1'b0;
    int             m_last  = 1;
    int             m_wait  = 0;
    logic           m_cyc;
    logic           m_exp;
    logic [11:0]    e_ctrl;
    logic [31:0]    e_adr, e_dat;
    logic [139:0]   e_all, g_all;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge i_clk);
      if (i_ibus_cyc) begin
        if ($urandom_range(0, 5) == 0) i_ibus_cyc = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        i_ibus_cyc = 1'b1; i_ibus_adr = $urandom;
      end
      if (i_dbus_cyc) begin
        if ($urandom_range(0, 5) == 0) i_dbus_cyc = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        i_dbus_cyc = 1'b1; i_dbus_adr = $urandom; i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom); i_dbus_we = 1'($urandom);
      end
      i_wb_ack = (c < 400) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      i_wb_rdt = $urandom;
      #1;
      m_cyc  = 1'b0;
      m_exp  = 1'b0;
      e_adr  = '0;
      e_dat  = '0;
      e_ctrl = {m_turn, 11'b0};
      if (m_owner == 1) begin
        m_cyc  = i_ibus_cyc;
        m_exp  = !i_wb_ack && m_cyc && (m_wait == TIMEOUT - 1);
        e_adr  = i_ibus_adr;
        e_ctrl = {1'b1, m_cyc, m_cyc, 1'b0, 4'hf, i_wb_ack, m_exp, 2'b00};
      end else if (m_owner == 2) begin
        m_cyc  = i_dbus_cyc;
        m_exp  = !i_wb_ack && m_cyc && (m_wait == TIMEOUT - 1);
        e_adr  = i_dbus_adr;
        e_dat  = i_dbus_dat;
        e_ctrl = {1'b1, m_cyc, m_cyc, i_dbus_we, i_dbus_sel, 2'b00, i_wb_ack, m_exp};
      end
      e_all = {e_ctrl, e_adr, e_dat, i_wb_rdt, i_wb_rdt};
      g_all = {ctrl(), o_wb_adr, o_wb_dat, o_ibus_rdt, o_dbus_rdt};
      n_tests++;
      if (g_all !== e_all) begin
        n_fail++; $display("FAIL random_cycle%0d got %h exp %h", c, g_all, e_all);
      end
      if (m_turn) begin
        m_turn = 1'b0;
      end else if (m_owner != 0) begin
        if (i_wb_ack || !m_cyc || m_exp) begin
          m_owner = 0; m_turn = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else if (i_ibus_cyc && i_dbus_cyc) begin
        m_owner = (m_last == 1) ? 2 : 1;
        m_last  = m_owner;
      end else if (i_dbus_cyc) begin
        m_owner = 2; m_last = 2;
      end else if (i_ibus_cyc) begin
        m_owner = 1; m_last = 1;
      end
    end
    quiesce();
    @(negedge i_clk);
  endtask

  initial begin
    quiesce();
    i_rst_n  = 1'b0;
    i_wb_rdt = '0;
    test_reset();
    test_ibus_fetch();
    test_tie_break();
    test_back_to_back();
    test_watchdog_expire();
    test_ack_on_last();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
